// File: rtl/conv_requant_out.sv
// Requantizing output stage for the conv engine: ReLU, rounding shift and 8-bit
// saturation, buffered in a FIFO and streamed out with per-image completion tracking.
module conv_requant_out #(
    parameter int FIFO_DEPTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ACC_WIDTH-1:0] result_in,
    input  logic                 result_valid_in,
    input  logic                 image_done_in,
    output logic                 accepting_out,
    input  logic [4:0]           shift_amt,
    input  logic                 relu_en,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam int VW = ACC_WIDTH + 1;

    localparam logic signed [VW-1:0] U8_MAX = VW'(255);
    localparam logic signed [VW-1:0] S8_MAX = VW'(127);
    localparam logic signed [VW-1:0] S8_MIN = VW'(-128);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    logic signed [VW-1:0] s1_ext, s1_bias, s1_sum, s1_val_d, s1_val_q;
    logic                 s1_valid_q, s1_relu_q;
    logic [7:0]           s2_data_d, s2_data_q;
    logic                 s2_valid_q;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]        count_d, count_q;
    logic                 push, pop, full, empty;
    logic [7:0]           out_data_d, out_data_q;

    logic [1:0]           inflight;
    logic [OW-1:0]        occupancy;
    logic                 accepting_q, overflow_q, image_done_q, img_rise;
    state_t               state_d, state_q;
    logic [CNT_WIDTH-1:0] out_count_q;

    // S1: optional ReLU, then round-half-up arithmetic shift at 33 bits so the bias cannot overflow.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        s1_ext  = {result_in[ACC_WIDTH-1], result_in};
        s1_bias = '0;
        if (relu_en && result_in[ACC_WIDTH-1]) s1_ext = '0;
        if (shift_amt != 5'd0) s1_bias = VW'(1) << (shift_amt - 5'd1);
        s1_sum   = s1_ext + s1_bias;
        s1_val_d = s1_sum >>> shift_amt;
    end

    always_comb begin
        s2_data_d = s1_val_q[7:0];
        if (s1_relu_q) begin
            if (s1_val_q[VW-1])        s2_data_d = 8'h00;
            else if (s1_val_q > U8_MAX) s2_data_d = 8'hFF;
        end else begin
            if (s1_val_q > S8_MAX)      s2_data_d = 8'h7F;
            else if (s1_val_q < S8_MIN) s2_data_d = 8'h80;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_relu_q  <= 1'b0;
            s1_val_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= result_valid_in;
            s1_relu_q  <= relu_en;
            s1_val_q   <= s1_val_d;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s2_data_d;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = !empty && out_ready;
    assign push    = s2_valid_q && (!full || pop);
    assign rd_next = rd_ptr_q + AW'(1);

    // Head byte is registered so it holds its last value when the FIFO runs empty.
    always_comb begin
        out_data_d = out_data_q;
        count_d    = count_q;
        if (pop) begin
            if (count_q == CW'(1)) begin
                if (push) out_data_d = s2_data_q;
            end else begin
                out_data_d = mem[rd_next];
            end
        end else if (push && empty) begin
            out_data_d = s2_data_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= s2_data_q;
    end

    assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
    assign occupancy = {1'b0, count_q} + OW'(inflight);
    assign img_rise  = image_done_in && !image_done_q;

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            ST_RUN:   if (img_rise) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight == 2'd0 && empty) begin
                frame_done = 1'b1;
                state_d    = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            accepting_q  <= 1'b0;
            overflow_q   <= 1'b0;
            image_done_q <= 1'b0;
            state_q      <= ST_RUN;
            out_count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_next;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            accepting_q  <= (occupancy <= OW'(FIFO_DEPTH - 3));
            if (s2_valid_q && full && !pop) overflow_q <= 1'b1;
            image_done_q <= image_done_in;
            state_q      <= state_d;
            if (frame_done) out_count_q <= '0;
            else if (pop)   out_count_q <= out_count_q + CNT_WIDTH'(1);
        end
    end

    assign accepting_out = accepting_q;
    assign out_data      = out_data_q;
    assign out_valid     = !empty;
    assign out_count     = out_count_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_conv_requant_out.sv
// Directed self-checking bench for conv_requant_out: arithmetic, latency, credit,
// overflow, full-throughput streaming, frame completion and mid-operation reset.
module tb_conv_requant_out;

    logic        clock;
    logic        reset;
    logic [31:0] result_in;
    logic        result_valid_in;
    logic        image_done_in;
    logic        accepting_out;
    logic [4:0]  shift_amt;
    logic        relu_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;
    logic [15:0] out_count;
    logic        overflow_err;

    int          checks;
    int          errors;
    int          cycle_cnt;
    int          last_pop_cycle;
    logic [7:0]  pop_q[$];

    conv_requant_out #(
        .FIFO_DEPTH(16),
        .ACC_WIDTH (32),
        .CNT_WIDTH (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .result_in      (result_in),
        .result_valid_in(result_valid_in),
        .image_done_in  (image_done_in),
        .accepting_out  (accepting_out),
        .shift_amt      (shift_amt),
        .relu_en        (relu_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .frame_done     (frame_done),
        .out_count      (out_count),
        .overflow_err   (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Records every byte that leaves the block, tagged with the cycle it was accepted in.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            pop_q.push_back(out_data);
            last_pop_cycle = cycle_cnt;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        result_valid_in = 1'b0;
        result_in       = '0;
        image_done_in   = 1'b0;
        out_ready       = 1'b0;
        relu_en         = 1'b0;
        shift_amt       = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        pop_q.delete();
    endtask

    task automatic send(input logic [31:0] v);
        result_in       = v;
        result_valid_in = 1'b1;
        tick();
        result_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1;
        tick();
        got = {out_valid, accepting_out, frame_done, overflow_err, 4'b0};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %0h expected 0", got);
        end
        checks++;
        if (out_data !== 8'h00 || out_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: out_data %0h out_count %0d expected 0 0", out_data, out_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (accepting_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_credit: got %0b expected 1", accepting_out);
        end
    endtask

    task automatic test_relu_shift();
        logic [7:0] exp_b[4] = '{8'd6, 8'd1, 8'd0, 8'd0};
        logic [7:0] got;
        do_reset();
        relu_en   = 1'b1;
        shift_amt = 5'd4;
        out_ready = 1'b1;
        result_in = 32'd100;
        result_valid_in = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: out_valid %0b expected 0", out_valid);
        end
        result_in = 32'd8;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c2: out_valid %0b expected 0", out_valid);
        end
        result_in = 32'd7;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd6) begin
            errors++;
            $display("FAIL latency_c3: out_valid %0b data %0d expected 1 6", out_valid, out_data);
        end
        result_in = -32'sd50;
        tick();
        result_valid_in = 1'b0;
        repeat (6) tick();
        checks++;
        if (pop_q.size() != 4) begin
            errors++;
            $display("FAIL relu_shift_count: got %0d expected 4", pop_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== exp_b[i]) begin
                errors++;
                $display("FAIL relu_shift[%0d]: got %0h expected %0h", i, got, exp_b[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_s[3] = '{8'h7F, 8'h80, 8'hFF};
        logic [7:0] exp_r[2] = '{8'hFF, 8'h00};
        logic [7:0] got;
        do_reset();
        out_ready = 1'b1;
        send(32'd300);
        send(-32'sd300);
        send(32'hFFFF_FFFF);
        repeat (6) tick();
        checks++;
        if (pop_q.size() != 3) begin
            errors++;
            $display("FAIL signed_sat_count: got %0d expected 3", pop_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== exp_s[i]) begin
                errors++;
                $display("FAIL signed_sat[%0d]: got %0h expected %0h", i, got, exp_s[i]);
            end
        end
        pop_q.delete();
        relu_en   = 1'b1;
        shift_amt = 5'd8;
        send(32'd70000);
        send(32'hFFFF_FFFF);
        repeat (6) tick();
        checks++;
        if (pop_q.size() != 2) begin
            errors++;
            $display("FAIL relu_sat_count: got %0d expected 2", pop_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== exp_r[i]) begin
                errors++;
                $display("FAIL relu_sat[%0d]: got %0h expected %0h", i, got, exp_r[i]);
            end
        end
    endtask

    task automatic test_credit_overflow();
        logic [7:0] got;
        do_reset();
        checks++;
        if (accepting_out !== 1'b1) begin
            errors++;
            $display("FAIL credit_idle: got %0b expected 1", accepting_out);
        end
        for (int k = 0; k < 16; k++) begin
            result_in       = 32'(k);
            result_valid_in = 1'b1;
            tick();
            if (k == 13) begin
                checks++;
                if (accepting_out !== 1'b1) begin
                    errors++;
                    $display("FAIL credit_at13: got %0b expected 1", accepting_out);
                end
            end
            if (k == 14) begin
                checks++;
                if (accepting_out !== 1'b0) begin
                    errors++;
                    $display("FAIL credit_at14: got %0b expected 0", accepting_out);
                end
            end
        end
        result_valid_in = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL full_no_ovf: out_valid %0b overflow %0b expected 1 0", out_valid, overflow_err);
        end
        send(32'd99);
        repeat (3) tick();
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %0b expected 1", overflow_err);
        end
        out_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (pop_q.size() != 16) begin
            errors++;
            $display("FAIL overflow_count: got %0d expected 16", pop_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== 8'(i)) begin
                errors++;
                $display("FAIL overflow_data[%0d]: got %0h expected %0h", i, got, i);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: out_valid %0b overflow %0b expected 0 1", out_valid, overflow_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        do_reset();
        for (int k = 0; k < 16; k++) send(32'(k));
        repeat (4) tick();
        for (int j = 0; j < 8; j++) begin
            result_in       = 32'(16 + j);
            result_valid_in = 1'b1;
            if (j == 2) out_ready = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %0b expected 1", j, out_valid);
            end
        end
        result_valid_in = 1'b0;
        repeat (30) tick();
        checks++;
        if (pop_q.size() != 24 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: popped %0d overflow %0b expected 24 0", pop_q.size(), overflow_err);
        end
        for (int i = 0; i < 24; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, got, i);
            end
        end
    endtask

    task automatic test_frame_done();
        int   pulses;
        int   fd_cycle;
        logic prev_fd;
        logic [7:0] got;
        pulses   = 0;
        fd_cycle = -1;
        prev_fd  = 1'b0;
        do_reset();
        for (int t = 0; t < 80; t++) begin
            out_ready = (t % 2 == 0);
            if (t < 9) begin
                result_in       = 32'(t + 1);
                result_valid_in = 1'b1;
            end else begin
                result_valid_in = 1'b0;
                image_done_in   = 1'b1;
            end
            if (prev_fd) begin
                checks++;
                if (out_count !== 16'd0) begin
                    errors++;
                    $display("FAIL frame_count_clear: got %0d expected 0", out_count);
                end
            end
            prev_fd = frame_done;
            if (frame_done) begin
                pulses++;
                fd_cycle = cycle_cnt;
                checks++;
                if (out_count !== 16'd9) begin
                    errors++;
                    $display("FAIL frame_count_at_pulse: got %0d expected 9", out_count);
                end
            end
            tick();
        end
        image_done_in = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL frame_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (fd_cycle != last_pop_cycle + 1) begin
            errors++;
            $display("FAIL frame_timing: pulse cycle %0d expected %0d", fd_cycle, last_pop_cycle + 1);
        end
        checks++;
        if (pop_q.size() != 9) begin
            errors++;
            $display("FAIL frame_pops: got %0d expected 9", pop_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== 8'(i + 1)) begin
                errors++;
                $display("FAIL frame_data[%0d]: got %0h expected %0h", i, got, i + 1);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] exp_m[3] = '{8'd10, 8'd20, 8'd30};
        logic [7:0] got;
        do_reset();
        for (int k = 1; k <= 5; k++) send(32'(k));
        repeat (3) tick();
        send(32'd77);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || accepting_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: valid %0b credit %0b done %0b expected 0 0 0",
                     out_valid, accepting_out, frame_done);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held: valid %0b count %0d done %0b expected 0 0 0",
                     out_valid, out_count, frame_done);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (accepting_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_credit: got %0b expected 1", accepting_out);
        end
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flushed: valid %0b done %0b expected 0 0", out_valid, frame_done);
        end
        pop_q.delete();
        out_ready = 1'b1;
        send(32'd10);
        send(32'd20);
        send(32'd30);
        repeat (6) tick();
        checks++;
        if (pop_q.size() != 3) begin
            errors++;
            $display("FAIL midreset_resume_count: got %0d expected 3", pop_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pop_q.size()) ? pop_q[i] : 8'hxx;
            checks++;
            if (got !== exp_m[i]) begin
                errors++;
                $display("FAIL midreset_resume[%0d]: got %0h expected %0h", i, got, exp_m[i]);
            end
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cycle_cnt       = 0;
        last_pop_cycle  = -1;
        reset           = 1'b1;
        result_in       = '0;
        result_valid_in = 1'b0;
        image_done_in   = 1'b0;
        out_ready       = 1'b0;
        relu_en         = 1'b0;
        shift_amt       = 5'd0;
        test_reset();
        test_relu_shift();
        test_saturation();
        test_credit_overflow();
        test_back_to_back();
        test_frame_done();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_requant_out.md
Name: conv_requant_out

Overview:
- Output stage directly downstream of the conv engine. Consumes its 32-bit accumulator results (result/resultValid/imageDone) and drives its out_accepting_values.
- Per result: applies optional ReLU, a rounding arithmetic right shift and saturation to 8 bits.
- Buffers the bytes in a FIFO and presents them on a valid/ready stream to the next layer / writeback.
- Tracks image completion and pulses frame_done once the last byte of an image has left the block.

Parameters:
- FIFO_DEPTH, 16, output FIFO entries; power of two, minimum 4.
- ACC_WIDTH, 32, width of the incoming accumulator result.
- CNT_WIDTH, 16, width of the out_count byte counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- result_in  in  ACC_WIDTH  signed accumulator value from conv
- result_valid_in  in  1  result_in valid this cycle (single-cycle qualifier)
- image_done_in  in  1  conv image-complete level; only its rising edge is used
- accepting_out  out  1  credit to conv (its out_accepting_values)
- shift_amt  in  5  right-shift amount, 0..31; must be stable while a frame is in progress
- relu_en  in  1  1: clamp negatives to 0 and saturate to 0..255; 0: signed saturate to -128..127
- out_data  out  8  requantized byte (FIFO head)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- frame_done  out  1  one-cycle pulse when an image is fully drained
- out_count  out  CNT_WIDTH  bytes popped since the last frame_done (wraps)
- overflow_err  out  1  sticky flag: a result was dropped because the FIFO was full

Behaviour:
- Reset values: all outputs 0, FIFO empty, pipeline empty, state RUN, image_done edge detector cleared.
- Reset mid-operation discards all in-flight data with no frame_done.

Pipeline (2 stages, fixed latency of 2 cycles from result_valid_in to FIFO write):
- S1, signed, 33-bit intermediate:
  - v = relu_en ? max(result_in, 0) : result_in.
  - If shift_amt > 0, add 1 << (shift_amt-1) (round half up), then shift arithmetically right by shift_amt.
- S2, saturation:
  - relu_en = 1: clamp to 0..255.
  - relu_en = 0: clamp to -128..127, stored as two's complement.
- A conv pad token (32'hFFFFFFFF = -1) needs no special case:
  - relu_en = 1 gives 8'h00.
  - relu_en = 0, shift 0 gives 8'hFF.
- Each stage has a valid bit. Occupancy (inflight) = s1_valid + s2_valid.

FIFO:
- Write when s2_valid is set.
- Pop when out_valid && out_ready. out_valid = !empty, and out_data = head entry.
- Full and pop in the same cycle: the push is accepted and count is unchanged.
- Full and no pop: the S2 word is dropped, overflow_err is set (sticky until reset) and count is unchanged.
- Empty: out_valid = 0 and out_data holds its last value. A push to an empty FIFO appears on out_valid the next cycle (no fall-through).
- Read/write pointers wrap modulo FIFO_DEPTH.

Credit:
- accepting_out = (fifo_count + inflight) <= FIFO_DEPTH - 3, registered.
- This margin covers conv pad emissions, which ignore the credit.

Frame FSM:
- RUN: a rising edge of image_done_in moves to DRAIN.
- DRAIN: when inflight == 0 and the FIFO is empty, pulse frame_done for 1 cycle, clear out_count the next cycle, go to RUN.
- A new rising edge during DRAIN is ignored.
- Results arriving during DRAIN are still processed and delay the exit.

out_count:
- Increments on each pop.
- If a pop coincides with the frame_done cycle, that pop is counted in the frame that is ending (the counter clears after it).

Test Plan:
- relu_en=1, shift_amt=4, results 100, 8, 7, -50 with out_ready=1 -> out_data 6, 1, 0, 0. First out_valid 3 cycles after the first result_valid_in.
- relu_en=0, shift_amt=0, results 300, -300, 32'hFFFFFFFF -> 8'h7F, 8'h80, 8'hFF. relu_en=1, results 70000, 32'hFFFFFFFF with shift 8 -> 8'hFF, 8'h00.
- out_ready=0, FIFO_DEPTH=16, 16 valid results -> accepting_out drops once count + inflight reaches 14. After 16 results out_valid stays 1 and overflow_err=0. A 17th result sets overflow_err=1 and count stays 16.
- FIFO full, out_ready=1 and result_valid_in every cycle -> one push and one pop per cycle, no drops, count steady at 16, data order preserved.
- 9 results, then image_done_in rising with out_ready toggling 1/0 -> frame_done pulses exactly once, 1 cycle after the 9th pop. out_count reads 9 at the pulse and 0 the next cycle. image_done_in held high produces no second pulse.
- Assert reset while the FIFO holds 5 entries and S1 is valid -> next cycle out_valid=0, accepting_out=0, frame_done=0, count 0. After reset release, accepting_out returns to 1 and the stream resumes cleanly.
